cdb_broadcaster: RTL

//  Transmit side of the common data bus. Collects completed results (ROB index + value) from the

---
 rtl/cdb_broadcaster.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cdb_broadcaster.sv
// Common data bus transmit side: per-source result FIFOs, round-robin lane packing.
// Define CDB_BYPASS_EN to let an empty-FIFO source reach the lanes in its push cycle.
module cdb_broadcaster #(
    parameter int NUM_SRC   = 6,
    parameter int NUM_LANES = 4,
    parameter int DEPTH     = 2,
    parameter int IDX_W     = 4,
    parameter int DATA_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*IDX_W-1:0]      src_rob_idx,
    input  logic [NUM_SRC*DATA_W-1:0]     src_result,
    output logic [NUM_LANES-1:0]          cdb_valid,
    output logic [NUM_LANES*IDX_W-1:0]    cdb_rob_idx,
    output logic [NUM_LANES*DATA_W-1:0]   cdb_result
);

    localparam int SP_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int EW   = IDX_W + DATA_W;

    logic [EW-1:0]   mem    [NUM_SRC][DEPTH];
    logic [AW-1:0]   rd_ptr [NUM_SRC];
    logic [AW-1:0]   wr_ptr [NUM_SRC];
    logic [CW-1:0]   count  [NUM_SRC];
    logic [SP_W-1:0] rr_ptr;

    logic [NUM_SRC-1:0]   cand;
    logic [NUM_SRC-1:0]   pop;
    logic [NUM_SRC-1:0]   byp;
    logic [NUM_SRC-1:0]   push;
    logic [NUM_LANES-1:0] lane_v;
    logic [EW-1:0]        lane_d [NUM_LANES];
    logic                 any_grant;
    logic [SP_W-1:0]      last_src;

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            src_ready[s] = rst_n & ~flush &
                           (count[s] < CW'(DEPTH));
            cand[s] = (count[s] != '0);
`ifdef CDB_BYPASS_EN
            if (count[s] == '0 && src_valid[s] && src_ready[s])
                cand[s] = 1'b1;
`endif
        end
    end

    // Scan from rr_ptr; the k-th grant in scan order fills lane k.
    always_comb begin : arb_p
        int n;
        int s;
        n         = 0;
        s         = 0;
        pop       = '0;
        byp       = '0;
        lane_v    = '0;
        any_grant = 1'b0;
        last_src  = '0;
        for (int k = 0; k < NUM_LANES; k++)
            lane_d[k] = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s = int'(rr_ptr) + i;
            if (s >= NUM_SRC)
                s = s - NUM_SRC;
            if (cand[s] && n < NUM_LANES) begin
                lane_v[n] = 1'b1;
                if (count[s] != '0) begin
                    pop[s]    = 1'b1;
                    lane_d[n] = mem[s][rd_ptr[s]];
                end else begin
                    byp[s]    = 1'b1;
                    lane_d[n] = {src_rob_idx[s*IDX_W +: IDX_W],
                                 src_result[s*DATA_W +: DATA_W]};
                end
                last_src  = SP_W'(s);
                any_grant = 1'b1;
                n         = n + 1;
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++)
            push[s] = src_valid[s] & src_ready[s] & ~byp[s];
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++)
            if (push[s])
                mem[s][wr_ptr[s]] <=
                    {src_rob_idx[s*IDX_W +: IDX_W],
                     src_result[s*DATA_W +: DATA_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end
            rr_ptr      <= '0;
            cdb_valid   <= '0;
            cdb_rob_idx <= '0;
            cdb_result  <= '0;
        end else if (flush) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end
            cdb_valid   <= '0;
            cdb_rob_idx <= '0;
            cdb_result  <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (push[s])
                    wr_ptr[s] <= wr_ptr[s] + AW'(1);
                if (pop[s])
                    rd_ptr[s] <= rd_ptr[s] + AW'(1);
                if (push[s] && !pop[s])
                    count[s] <= count[s] + CW'(1);
                else if (pop[s] && !push[s])
                    count[s] <= count[s] - CW'(1);
            end
            for (int k = 0; k < NUM_LANES; k++) begin
                cdb_valid[k] <= lane_v[k];
                cdb_rob_idx[k*IDX_W +: IDX_W] <=
                    lane_d[k][EW-1:DATA_W];
                cdb_result[k*DATA_W +: DATA_W] <=
                    lane_d[k][DATA_W-1:0];
            end
            if (any_grant)
                rr_ptr <= (last_src == SP_W'(NUM_SRC - 1)) ?
                          '0 : last_src + SP_W'(1);
        end
    end

endmodule
